debounce_event: RTL
===================

DEBOUNCE_EVENT -- requirements
Module: debounce_event

Interface
REQ-001 WIDTH, 4, number of independent input channels (>=1).
REQ-002 N, 4, consecutive agreeing samples required to change a debounced level (>=2).
REQ-003 RATE, 125000, clk cycles per sample tick (>=1).
REQ-004 LONG_TICKS, 250, sample ticks a level must stay high before a long-press event (>=1).
REQ-005 clk  input  1  sole clock; all logic is on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 in  input  WIDTH  raw asynchronous switch/button levels.
REQ-008 out  output  WIDTH  debounced level per channel.
REQ-009 rise  output  WIDTH  one-cycle pulse per channel on an out 0->1 change.
REQ-010 fall  output  WIDTH  one-cycle pulse per channel on an out 1->0 change.
REQ-011 long  output  WIDTH  one-cycle pulse per channel on a long-press event.
REQ-012 tick  output  1  one-cycle sample strobe, for use by neighbouring logic.

Function
REQ-013 Each in bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-014 Prescaler: the counter SHALL count 0..RATE-1 and wrap, with tick high in the cycle the count equals RATE-1; with RATE=1, tick SHALL be high every cycle.
REQ-015 Prescaler width SHALL be $clog2(RATE), minimum 1 bit.
REQ-016 On tick only, each channel SHALL shift its synchronised bit into its own N-bit history register.
REQ-017 out[k] SHALL become 1 the cycle after the history is all ones, become 0 the cycle after it is all zeros, and otherwise hold.
REQ-018 rise[k] and fall[k] SHALL be high exactly in the first cycle out[k] shows its new value, and SHALL never be high together.
REQ-019 Latency: a clean input step SHALL reach out no later than 2 + N*RATE + 1 cycles after the step.
REQ-020 A glitch shorter than (N-1)*RATE cycles SHALL NOT change out.
REQ-021 Hold counter per channel, width $clog2(LONG_TICKS+1):
  - increments on tick while out[k]=1;
  - saturates at LONG_TICKS;
  - clears to 0 in the cycle out[k] falls.
REQ-022 long[k] SHALL pulse once, in the cycle the hold counter reaches LONG_TICKS, with no repeat until out[k] has fallen and risen again.
REQ-023 If out[k] falls in the same cycle its counter would reach LONG_TICKS, the clear SHALL win and long[k] SHALL stay low.
REQ-024 Channels SHALL be fully independent; simultaneous events on any set of channels SHALL all be reported in the same cycle.

Reset
REQ-025 While rst is high, all of the following SHALL be 0: synchronisers, history registers, prescaler, hold counters, out, rise, fall, long and tick.
REQ-026 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge.
REQ-027 No event pulse SHALL be generated by reset assertion or deassertion; an input held at 1 through reset SHALL produce a normal rise after debounce.

Configuration
REQ-028 DEBOUNCE_EVENT_LONG_PRESS_EN defined:
  - REQ-021..REQ-023 are implemented.
REQ-029 DEBOUNCE_EVENT_LONG_PRESS_EN undefined:
  - hold counters are not built;
  - long SHALL be constant 0;
  - LONG_TICKS SHALL be ignored;
  - all other behaviour is unchanged.

Structure
REQ-030 No shared package is required; all constants are module parameters and there are no typedefs.
REQ-031 The prescaler SHALL be a sub-module, debounce_tick_gen (parameter RATE; ports clk, rst, tick).

Verification
REQ-032 Common setup: WIDTH=4, N=4, RATE=10, LONG_TICKS=5, long-press macro defined.
REQ-033 Reset: hold rst for 3 cycles with in=4'hF -> all outputs 0 during reset; out=4'hF with a single rise=4'hF pulse within 43 cycles after release.
REQ-034 Bounce: in[0] toggles every 3 cycles for 25 cycles, then stays 1 -> exactly one rise[0] pulse, no fall[0], out[0]=1.
REQ-035 Long press: hold in[1]=1 -> long[1] pulses exactly once, 5 ticks (50 cycles) after rise[1]; no further long[1] pulse over 200 cycles.
REQ-036 Early release: in[2] high for 3 ticks after its rise, then low -> fall[2] pulses once and long[2] never pulses.
REQ-037 Independence: in steps from 4'h0 to 4'h5 in one cycle -> rise=4'h5 in a single cycle, and bits 1 and 3 of out, rise, fall and long stay 0.
REQ-038 Macro off: rerun the long-press scenario -> long stays 4'h0 and rise/fall timing is identical to the macro-on run.

Source files
------------

// File: rtl/debounce_event_pkg.sv
// -----------------------------------------------------------------------------
// debounce_event_pkg
//
// Purpose : Elaboration-time helpers shared by the debounce_event block.
//           Holds no types and no constants; every tunable value stays a
//           module parameter of the module that uses it.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package debounce_event_pkg;

    // Bits needed to hold the values 0..value-1, never less than one bit so a
    // degenerate range still yields a legal vector.
    function automatic int width_of(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// -----------------------------------------------------------------------------
// debounce_tick_gen
//
// Purpose : Sample-rate prescaler. A counter runs 0..RATE-1 and wraps. tick is
//           high in exactly the cycles where the count equals RATE-1, so with
//           RATE=1 it is high in every cycle out of reset.
// Params  : RATE - clk cycles per tick (>=1).
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           tick - one-cycle sample strobe
// -----------------------------------------------------------------------------
module debounce_tick_gen
    import debounce_event_pkg::*;
#(
    parameter int RATE = 125000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int              CNT_W = width_of(RATE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RATE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // tick is registered alongside the count: tick_q mirrors (cnt_q == LAST),
    // but stays 0 while rst is high even when RATE=1 makes LAST zero.
    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_d == LAST);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/debounce_event.sv
// -----------------------------------------------------------------------------
// debounce_event
//
// Purpose : Multi-channel switch debouncer with edge and long-press events.
//           Each raw input is synchronised (2 flops), sampled on a prescaled
//           tick into an N-deep history, and the debounced level changes only
//           when the whole history agrees. rise/fall pulse in the first cycle
//           out shows its new value.
// Build   : define DEBOUNCE_EVENT_LONG_PRESS_EN to build the per-channel hold
//           counters and the long-press event. Without it, long is tied to 0
//           and LONG_TICKS has no effect.
// Params  : WIDTH      - number of independent channels (>=1)
//           N          - agreeing samples needed to change a level (>=2)
//           RATE       - clk cycles per sample tick (>=1)
//           LONG_TICKS - ticks held high before a long-press event (>=1)
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           in   - raw asynchronous levels, one per channel
//           out  - debounced levels
//           rise - one-cycle pulse on out 0->1
//           fall - one-cycle pulse on out 1->0
//           long - one-cycle long-press pulse
//           tick - sample strobe, exported for neighbouring logic
// -----------------------------------------------------------------------------
module debounce_event
    import debounce_event_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int N          = 4,
    parameter int RATE       = 125000,
    parameter int LONG_TICKS = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] long,
    output logic             tick
);

    logic                      tick_w;
    logic [WIDTH-1:0]          sync1_q, sync2_q;
    logic [WIDTH-1:0][N-1:0]   hist_q, hist_d;
    logic [WIDTH-1:0]          out_q, out_d;
    logic [WIDTH-1:0]          rise_q, fall_q;

    debounce_tick_gen #(
        .RATE (RATE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_w)
    );

    // Two-flop synchroniser; nothing downstream looks at in directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        hist_d = hist_q;
        out_d  = out_q;
        for (int k = 0; k < WIDTH; k++) begin
            if (tick_w) begin
                hist_d[k] = {hist_q[k][N-2:0], sync2_q[k]};
            end
            if (&hist_q[k]) begin
                out_d[k] = 1'b1;
            end else if (~|hist_q[k]) begin
                out_d[k] = 1'b0;
            end
        end
    end

    // The events are registered next to out, so they appear in the same cycle
    // out first shows the new value; rise and fall are mutually exclusive by
    // construction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the history is small per-channel state, not a RAM, and it
            // must be cleared: a stale all-ones history would raise out
            // straight out of reset with no debounce.
            hist_q <= '0;
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            hist_q <= hist_d;
            out_q  <= out_d;
            rise_q <= out_d & ~out_q;
            fall_q <= ~out_d & out_q;
        end
    end

`ifdef DEBOUNCE_EVENT_LONG_PRESS_EN
    localparam int               HOLD_W   = width_of(LONG_TICKS + 1);
    localparam logic [HOLD_W-1:0] LONG_MAX = HOLD_W'(LONG_TICKS);

    logic [WIDTH-1:0][HOLD_W-1:0] hold_q, hold_d;
    logic [WIDTH-1:0]             long_q, long_d;

    // The counter is driven from out_d so a falling edge clears it in the same
    // edge that drops out, which also beats an increment landing on that edge.
    // long fires only on the transition into LONG_MAX; saturation stops it
    // from repeating until a fall has cleared the counter.
    always_comb begin
        hold_d = hold_q;
        long_d = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (!out_d[k]) begin
                hold_d[k] = '0;
            end else if (tick_w && out_q[k] && (hold_q[k] != LONG_MAX)) begin
                hold_d[k] = hold_q[k] + 1'b1;
            end
            long_d[k] = (hold_d[k] == LONG_MAX) && (hold_q[k] != LONG_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= '0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long = long_q;
`else
    // Always zero for any legal LONG_TICKS; the parameter is referenced only so
    // both builds share one parameter list without an unused parameter.
    assign long = {WIDTH{LONG_TICKS < 0}};
`endif

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign tick = tick_w;

endmodule
